// File: rtl/params_pkg.sv
// Shared parameters for the Kyber coefficient feeder: datapath width,
// the Kyber modulus q = 3329 with its bit length, and the feeder FSM states.
package params_pkg;

  localparam int DATA_LENGTH    = 24;
  localparam int MODULUS        = 3329;
  localparam int MODULUS_LENGTH = 12;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    ISSUE,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/kyber_coef_feeder.sv
// Kyber coefficient feeder.
// Accepts one coefficient pair (a, b), forms the product a*b in a register and
// hands it to a downstream modular reducer with a one-cycle start pulse. The
// reducer result is presented on a valid/ready output port. A per-polynomial
// counter tracks completed coefficients and pulses poly_done_o on the last one.
//
// Optional build macro KYBER_FEEDER_BYPASS_EN: when defined, products already
// below the modulus skip the reducer and go straight to the output.
module kyber_coef_feeder #(
  parameter int DATA_LENGTH = params_pkg::DATA_LENGTH,
  parameter int COEF_WIDTH  = 12,
  parameter int POLY_N      = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [COEF_WIDTH-1:0]     a_i,
  input  logic [COEF_WIDTH-1:0]     b_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic                      red_start_o,
  output logic [DATA_LENGTH-1:0]    red_x_o,
  output logic [DATA_LENGTH-1:0]    red_m_o,
  output logic [DATA_LENGTH-1:0]    red_m_bl_o,
  input  logic [DATA_LENGTH-1:0]    red_result_i,
  input  logic                      red_valid_i,
  output logic [DATA_LENGTH-1:0]    out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [$clog2(POLY_N)-1:0] count_o,
  output logic                      poly_done_o
);

  import params_pkg::*;

  localparam int CW = $clog2(POLY_N);
  localparam int PW = 2 * COEF_WIDTH;

  state_t          state;
  logic [PW-1:0]   product;
  logic [CW-1:0]   count;

  assign product = PW'(a_i) * PW'(b_i);

  // Ready is a pure decode of the idle state, held low while reset is applied
  // so the very first cycle after reset can already accept a coefficient.
  assign in_ready_o = (state == IDLE) && !rst_i;
  assign red_m_o    = DATA_LENGTH'(MODULUS);
  assign red_m_bl_o = DATA_LENGTH'(MODULUS_LENGTH);
  assign count_o    = count;

  // Feeder FSM: latch product, issue to reducer, wait for result, hand off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      red_start_o <= 1'b0;
      red_x_o     <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      count       <= '0;
      poly_done_o <= 1'b0;
    end else begin
      red_start_o <= 1'b0;
      poly_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            red_x_o <= DATA_LENGTH'(product);
            state   <= MUL;
          end
        end
        MUL: begin
`ifdef KYBER_FEEDER_BYPASS_EN
          if (red_x_o < DATA_LENGTH'(MODULUS)) begin
            out_data_o  <= red_x_o;
            out_valid_o <= 1'b1;
            state       <= OUT;
          end else begin
            red_start_o <= 1'b1;
            state       <= ISSUE;
          end
`else
          red_start_o <= 1'b1;
          state       <= ISSUE;
`endif
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (red_valid_i) begin
            out_data_o  <= red_result_i;
            out_valid_o <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
            if (count == CW'(POLY_N - 1)) begin
              count       <= '0;
              poly_done_o <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_coef_feeder.sv
// Testbench for kyber_coef_feeder.
// Plays the role of the downstream reducer (result = x mod 3329 after a chosen
// latency) and of the output consumer, and predicts every output from the
// arithmetic of the coefficient pair plus a running coefficient count.
// Honours KYBER_FEEDER_BYPASS_EN when predicting start pulses and latency.
module tb_kyber_coef_feeder;

  localparam int DL = 24;
  localparam int Q  = 3329;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [11:0]   a_i, b_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          red_start_o;
  logic [DL-1:0] red_x_o, red_m_o, red_m_bl_o;
  logic [DL-1:0] red_result_i;
  logic          red_valid_i;
  logic [DL-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [7:0]    count_o;
  logic          poly_done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int model_count = 0;
  int pd_total = 0;

  kyber_coef_feeder #(.DATA_LENGTH(DL), .COEF_WIDTH(12), .POLY_N(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_i(a_i), .b_i(b_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .red_start_o(red_start_o), .red_x_o(red_x_o), .red_m_o(red_m_o),
    .red_m_bl_o(red_m_bl_o), .red_result_i(red_result_i), .red_valid_i(red_valid_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .count_o(count_o), .poly_done_o(poly_done_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full coefficient transaction: accept, optional reducer round-trip,
  // hold the output for 'hold' cycles, then complete the output handshake.
  task automatic apply_stimulus(input logic [11:0] a, input logic [11:0] b,
                                input int lat, input int hold, input bit noise);
    int prod, expv, cyc, nstart, exp_start, exp_lat;
    bit done, exp_pd;
    logic [DL-1:0] prev_data;
    prod = int'(a) * int'(b);
    expv = prod % Q;
    exp_start = 1;
`ifdef KYBER_FEEDER_BYPASS_EN
    if (prod < Q) exp_start = 0;
`endif
    exp_lat = (exp_start == 1) ? 3 + lat : 2;

    @(negedge clk_i);
    check_output("in_ready_idle", in_ready_o, 1);
    prev_data = out_data_o;
    a_i = a; b_i = b; in_valid_i = 1'b1;
    if (noise) begin
      red_valid_i  = 1'b1;
      red_result_i = 24'h5A5A5;
    end
    @(posedge clk_i); #1 in_valid_i = 1'b0;
    @(negedge clk_i);
    cyc = 1;
    check_output("red_x_product", red_x_o, prod);
    check_output("in_ready_busy", in_ready_o, 0);
    check_output("poly_done_low", poly_done_o, 0);
    if (noise) begin
      check_output("noise_data_kept", out_data_o, prev_data);
      check_output("noise_no_valid", out_valid_o, 0);
    end

    done = 0;
    nstart = 0;
    while (!done && cyc < 40) begin
      if (noise && cyc >= 2) red_valid_i = 1'b0;
      if (out_valid_o) begin
        done = 1;
      end else begin
        if (red_start_o) begin
          nstart++;
          for (int i = 0; i < lat; i++) begin
            @(negedge clk_i);
            cyc++;
            check_output("start_one_cycle", red_start_o, 0);
            check_output("red_x_stable", red_x_o, prod);
          end
          red_valid_i  = 1'b1;
          red_result_i = DL'(expv);
          @(posedge clk_i); #1;
          red_valid_i  = 1'b0;
          red_result_i = DL'($urandom);
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    if (!done) begin
      check_output("out_valid_timeout", 0, 1);
      return;
    end
    check_output("latency", cyc, exp_lat);
    check_output("start_pulses", nstart, exp_start);
    check_output("out_data", out_data_o, expv);

    for (int i = 0; i < hold; i++) begin
      check_output("hold_data", out_data_o, expv);
      check_output("hold_valid", out_valid_o, 1);
      check_output("hold_in_ready", in_ready_o, 0);
      check_output("hold_count", count_o, model_count);
      @(negedge clk_i);
    end

    out_ready_i = 1'b1;
    @(posedge clk_i); #1 out_ready_i = 1'b0;
    exp_pd = (model_count == 255);
    model_count = (model_count + 1) % 256;
    @(negedge clk_i);
    check_output("count", count_o, model_count);
    check_output("poly_done", poly_done_o, exp_pd);
    check_output("out_valid_drop", out_valid_o, 0);
    if (poly_done_o) pd_total++;
  endtask

  initial begin
    int cyc;
    rst_i = 1'b1; a_i = '0; b_i = '0; in_valid_i = 1'b0;
    red_valid_i = 1'b0; red_result_i = '0; out_ready_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check_output("rst_in_ready", in_ready_o, 0);
    check_output("rst_red_start", red_start_o, 0);
    check_output("rst_red_x", red_x_o, 0);
    check_output("rst_out_data", out_data_o, 0);
    check_output("rst_out_valid", out_valid_o, 0);
    check_output("rst_count", count_o, 0);
    check_output("rst_poly_done", poly_done_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_output("post_rst_in_ready", in_ready_o, 1);
    check_output("red_m", red_m_o, Q);
    check_output("red_m_bl", red_m_bl_o, 12);

    // Largest product, slow reducer
    apply_stimulus(12'd3328, 12'd3328, 5, 0, 1'b0);
    // Small product (bypass candidate)
    apply_stimulus(12'd2, 12'd3, 3, 0, 1'b0);
    // Consumer stalls for 10 cycles
    apply_stimulus(12'd1234, 12'd2711, 2, 10, 1'b0);
    // Stray reducer valid while idle and during MUL
    apply_stimulus(12'd77, 12'd999, 1, 0, 1'b1);

    // Reset while waiting on the reducer, then a late reducer valid
    @(negedge clk_i);
    a_i = 12'd100; b_i = 12'd200; in_valid_i = 1'b1;
    @(posedge clk_i); #1 in_valid_i = 1'b0;
    cyc = 0;
    while (!red_start_o && cyc < 10) begin
      @(negedge clk_i);
      cyc++;
    end
    check_output("wait_rst_saw_start", red_start_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    red_valid_i = 1'b1; red_result_i = 24'd123;
    @(posedge clk_i); #1 red_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_output("wait_rst_no_valid", out_valid_o, 0);
    end
    check_output("wait_rst_in_ready", in_ready_o, 1);
    check_output("wait_rst_out_data", out_data_o, 0);
    check_output("wait_rst_red_x", red_x_o, 0);
    check_output("wait_rst_count", count_o, 0);
    check_output("wait_rst_start", red_start_o, 0);
    check_output("wait_rst_poly_done", poly_done_o, 0);
    model_count = 0;

    // A full polynomial of back-to-back random coefficients
    pd_total = 0;
    for (int k = 0; k < 256; k++) begin
      apply_stimulus(12'($urandom_range(0, Q - 1)), 12'($urandom_range(0, Q - 1)),
                     int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 1'b0);
    end
    check_output("poly_done_once", pd_total, 1);
    check_output("count_wrapped", count_o, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kyber_coef_feeder.md
KYBER_COEF_FEEDER -- requirements
Module: kyber_coef_feeder

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default params_pkg::DATA_LENGTH, reducer datapath width.
REQ-002 SHALL have parameter COEF_WIDTH, default 12, width of each input coefficient.
REQ-003 SHALL have parameter POLY_N, default 256, coefficients per polynomial.
REQ-004 SHALL have clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have a_i, b_i  in  COEF_WIDTH each  coefficient operands.
REQ-007 SHALL have in_valid_i  in  1 and in_ready_o  out  1  input handshake.
REQ-008 SHALL have red_start_o  out  1  one-cycle start pulse to the downstream reducer.
REQ-009 SHALL have red_x_o, red_m_o, red_m_bl_o  out  DATA_LENGTH each  the value to reduce, MODULUS and MODULUS_LENGTH.
REQ-010 SHALL have red_result_i  in  DATA_LENGTH and red_valid_i  in  1  reducer result and its valid.
REQ-011 SHALL have out_data_o  out  DATA_LENGTH, out_valid_o  out  1 and out_ready_i  in  1  output handshake.
REQ-012 SHALL have count_o  out  $clog2(POLY_N)  coefficients completed in the current polynomial.
REQ-013 SHALL have poly_done_o  out  1  one-cycle pulse when the POLY_N-th coefficient is accepted at the output.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, ISSUE, WAIT, OUT.
REQ-015 SHALL assert in_ready_o only in IDLE; on in_valid_i && in_ready_o, SHALL latch a_i*b_i, zero-extended to DATA_LENGTH, and move to MUL.
REQ-016 SHALL go from MUL to ISSUE after one cycle, with red_x_o holding the registered product.
REQ-017 SHALL pulse red_start_o high for exactly one cycle in ISSUE, then move to WAIT.
REQ-018 SHALL hold red_x_o stable from MUL until WAIT exits.
REQ-019 SHALL drive red_m_o = MODULUS and red_m_bl_o = MODULUS_LENGTH constantly.
REQ-020 SHALL wait in WAIT with no cycle limit; the first cycle with red_valid_i=1 SHALL capture red_result_i into out_data_o and move to OUT.
REQ-021 SHALL ignore red_valid_i in every state other than WAIT.
REQ-022 SHALL assert out_valid_o only in OUT and hold out_data_o stable until out_ready_i=1.
REQ-023 On out_valid_o && out_ready_i, SHALL increment count_o and return to IDLE.
REQ-024 When count_o = POLY_N-1 at the output handshake, SHALL set count_o to 0 and pulse poly_done_o in the same cycle.
REQ-025 Minimum latency (bypass not active), input handshake to out_valid_o, SHALL be 3 cycles plus the reducer latency.

Reset
REQ-026 On rst_i=1 at a clock edge, SHALL enter IDLE from any state, including WAIT and OUT.
REQ-027 Reset SHALL clear in_ready_o (high from the first cycle after reset), red_start_o, red_x_o, out_data_o, out_valid_o, count_o and poly_done_o to 0.
REQ-028 A red_valid_i that arrives after a mid-operation reset SHALL be ignored.

Configuration
REQ-029 Macro KYBER_FEEDER_BYPASS_EN SHALL control bypass.
REQ-030 With the macro defined, a product < MODULUS in MUL SHALL go directly to OUT with out_data_o = product, and no red_start_o pulse.
REQ-031 Without the macro, every product SHALL go through ISSUE/WAIT.

Structure
REQ-032 DATA_LENGTH, MODULUS (3329), MODULUS_LENGTH (12) and the FSM state enum SHALL live in params_pkg.
REQ-033 SHALL be one module with no sub-modules; the multiplier is an inferred registered product.

Verification
REQ-034 a=3328, b=3328 (product 0xA90000), reducer model latency 5 -> one red_start_o pulse, out_data_o=1.
REQ-035 a=2, b=3: with the macro, out_data_o=6, no red_start_o, out_valid_o 2 cycles after accept; without the macro, out_data_o=6 via the reducer.
REQ-036 out_ready_i held low 10 cycles in OUT -> out_data_o and out_valid_o held, in_ready_o=0, count_o unchanged.
REQ-037 256 back-to-back coefficients -> poly_done_o pulses exactly once, on the 256th output handshake, and count_o returns to 0.
REQ-038 rst_i pulsed during WAIT, then red_valid_i=1 -> all outputs 0, FSM in IDLE, no out_valid_o.
REQ-039 red_valid_i=1 while in IDLE or MUL -> no state change and out_data_o unchanged.
